inst_fetch: RTL

Instruction-fetch stage that sits directly downstream of the PC register. It takes the current fetch PC and its address-exception flag and drives one SRAM-like read per instruction toward the instruction-side AXI bridge. It holds the returned word for the decode stage and stalls the PC until the word is delivered. On an exception or redirect (flush) it cancels the fetch: a response already in flight is drained and discarded.

---
 rtl/inst_fetch.sv | 114 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one SRAM-like read per PC, holds the word for decode
// and stalls the PC register until that word has been accepted.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_exc_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] exc_o,
    output logic        valid_o,
    output logic        stall_req_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] exc_q, exc_d;
    logic        misaligned;

    assign misaligned = pc_exc_i[31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            inst_q  <= 32'h0;
            pc_q    <= 32'h0;
            exc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        exc_d       = exc_q;
        inst_req    = 1'b0;
        inst_addr   = pc_i;
        valid_o     = 1'b0;
        stall_req_o = 1'b1;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                inst_req = !misaligned;
                // A flushed request that was still accepted leaves a response to drain.
                if (flush_i) begin
                    if (!misaligned && inst_addr_ok) begin
                        state_d = DROP;
                    end
                end else if (misaligned) begin
                    state_d = HOLD;
                    inst_d  = 32'h0;
                    pc_d    = pc_i;
                    exc_d   = pc_exc_i;
                end else if (inst_addr_ok) begin
                    state_d = WAIT;
                    pc_d    = pc_i;
                    exc_d   = pc_exc_i;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = inst_data_ok ? REQ : DROP;
                end else if (inst_data_ok) begin
                    state_d = HOLD;
                    inst_d  = inst_rdata;
                end
            end
            HOLD: begin
                valid_o     = 1'b1;
                stall_req_o = 1'b0;
                if (flush_i || !stall_i) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (inst_data_ok) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign exc_o  = exc_q;

endmodule
